i2c_register_access: RTL and testbench
======================================

Name: i2c_register_access

Overview:
- Parametrised successor to the single-byte camera I2C register writer.
- Performs full register transactions over the byte-level I2C send engine: multi-byte register address, multi-byte data, register reads, optional read-back verify, and bounded retry on NACK or mismatch.
- Sits between the camera configuration sequencer (above) and the byte engine (below, external to this block).

Parameters:
- ADDR_BYTES, 1, register address width in bytes (legal 1..2).
- DATA_BYTES, 1, register data width in bytes (legal 1..4).
- VERIFY_EN, 0, 1 = every write is followed by a read-back and compare.
- MAX_RETRIES, 0, extra attempts after a failure (legal 0..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- i2c_addr  in  7  target device address.
- reg_addr  in  8*ADDR_BYTES  register address; MSB byte sent first.
- reg_wdata  in  8*DATA_BYTES  write data; MSB byte sent first.
- reg_op_rd  in  1  0 = write, 1 = read; sampled with reg_op_start.
- reg_op_start  in  1  request; honoured only while reg_op_ready=1.
- reg_op_ready  out  1  internal ready AND i2c_send_ready.
- reg_op_done  out  1  1-clk completion pulse.
- reg_op_err  out  2  0 = ok, 1 = NACK, 2 = verify mismatch; valid with done, held until next start.
- reg_rdata  out  8*DATA_BYTES  read or read-back data; valid with done.
- tx_data  out  8  byte to send.
- i2c_start  out  1  prepend START / repeated START to this byte.
- i2c_stop  out  1  append STOP after this byte.
- i2c_read  out  1  this byte operation is a read.
- i2c_read_nack  out  1  master NACKs this read byte (last byte).
- tx_start  out  1  1-clk trigger for a byte operation.
- i2c_send_done  in  1  1-clk byte-operation completion.
- i2c_send_ready  in  1  byte engine idle.
- rx_data  in  8  received byte; valid with i2c_send_done when i2c_read=1.
- i2c_ack_err  in  1  slave NACKed; valid with i2c_send_done. The engine issues STOP itself on NACK.

Behaviour:
- Reset values: all outputs 0, state IDLE, retry count 0. reg_op_ready rises the first clk after rst deasserts, given i2c_send_ready=1.
- Reset mid-transaction: immediate return to IDLE with no done pulse; the byte engine is reset by the same rst.
- IDLE:
  - Drive ready=1 and clear done.
  - On start AND i2c_send_ready: latch addr, reg_addr, wdata and rd; clear retry count; ready falls next clk.
  - Start while busy is ignored; nothing is queued.
- Byte issue protocol, used for every byte: ISSUE state drives tx_data, flags and tx_start=1 for exactly 1 clk. The paired WAIT state drops tx_start and advances on i2c_send_done.
- Write phase, 1+ADDR_BYTES+DATA_BYTES bytes:
  - SADDR {addr,0} with i2c_start=1.
  - ADDR bytes, MSB first.
  - DATA bytes, MSB first; i2c_stop=1 on the last one.
- Read phase:
  - SADDR {addr,0} with start, then ADDR bytes, no stop.
  - SADDR {addr,1} with repeated start.
  - DATA_BYTES reads, i2c_read=1, each shifted into reg_rdata MSB first; last read has i2c_read_nack=1 and i2c_stop=1.
- Write with VERIFY_EN=1: the write phase is followed by a full read phase. On completion, compare reg_rdata with the latched wdata; a mismatch is a failure with err=2.
- NACK: i2c_ack_err=1 with send_done on any non-read byte aborts the remaining bytes; failure with err=1.
- Failure handling:
  - If retry count < MAX_RETRIES: increment it and restart from the first SADDR of the write (or read) phase after 1 idle clk.
  - Otherwise: done=1 with the err code, then IDLE.
- Success: done=1, err=0, then IDLE.
- Byte counter is 3 bits wide, reset per phase, and never wraps with legal parameters.
- Latency, write without verify: (1+ADDR_BYTES+DATA_BYTES) × (engine time + 2 clk) + 2 clk from accepted start to done.
- i2c_send_done while not in a WAIT state is ignored.

Decomposition:
- Package i2c_access_pkg:
  - state encoding localparams: IDLE, SADDR_W, SADDR_W_WAIT, RADDR, RADDR_WAIT, WDATA, WDATA_WAIT, SADDR_R, SADDR_R_WAIT, RDATA, RDATA_WAIT, CHECK, RETRY;
  - err codes ERR_OK/ERR_NACK/ERR_VERIFY;
  - RW bit constants.
- Natural sub-module: i2c_byte_slicer. It selects byte k (MSB first) from a variable-width vector and assembles received bytes into reg_rdata.
- The byte engine is instantiated by the parent, not inside this block.

Test Plan:
- ADDR_BYTES=2, DATA_BYTES=1, write addr=0x30, reg 0x3012, data 0xA5 → tx bytes 0x60,0x30,0x12,0xA5; start on byte 1 only, stop on byte 4 only; done 1 clk, err=0.
- DATA_BYTES=2, read reg 0x0C with slave returning 0xBE,0xEF → bytes 0x60,0x0C, repeated start 0x61, two reads with nack+stop on the 2nd; reg_rdata=0xBEEF.
- VERIFY_EN=1, slave returns 0x5A after write of 0xA5, MAX_RETRIES=1 → two full write+read attempts, then done with err=2.
- Slave NACKs the 2nd address byte, MAX_RETRIES=0 → data bytes not sent; done with err=1.
- rst pulsed during the WDATA wait → all outputs 0 at once, no done pulse; ready=1 the clk after release; a new write then completes normally.
- start held high through a transaction → exactly one transaction per start accepted while ready=1; a start while ready=0 is ignored.

Source files
------------

// File: rtl/i2c_access_pkg.sv
// Shared types and constants for the I2C register access controller.
package i2c_access_pkg;

  // Controller states: each byte uses an ISSUE state and its paired WAIT state.
  typedef enum logic [3:0] {
    IDLE,
    SADDR_W,
    SADDR_W_WAIT,
    RADDR,
    RADDR_WAIT,
    WDATA,
    WDATA_WAIT,
    SADDR_R,
    SADDR_R_WAIT,
    RDATA,
    RDATA_WAIT,
    CHECK,
    RETRY
  } state_e;

  // Completion codes reported on reg_op_err.
  typedef enum logic [1:0] {
    ERR_OK     = 2'd0,
    ERR_NACK   = 2'd1,
    ERR_VERIFY = 2'd2
  } err_e;

  // R/W bit appended to the 7-bit device address.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Slave-address byte as it goes on the wire.
  function automatic logic [7:0] saddr_byte(input logic [6:0] dev, input logic rw);
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_byte_slicer.sv
// Byte selection (MSB first) from the latched register address or write data,
// and placement of received bytes into the read-data vector.
module i2c_byte_slicer #(
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 1
) (
  input  logic [8*ADDR_BYTES-1:0] addr_vec,
  input  logic [8*DATA_BYTES-1:0] data_vec,
  input  logic                    sel_data,
  input  logic [2:0]              idx,
  output logic [7:0]              byte_out,
  input  logic [8*DATA_BYTES-1:0] rdata_cur,
  input  logic [7:0]              rx_byte,
  output logic [8*DATA_BYTES-1:0] rdata_next
);

  // Pick byte idx of the selected vector; byte 0 is the most significant.
  always_comb begin
    byte_out = '0;
    for (int k = 0; k < ADDR_BYTES; k++) begin
      if (!sel_data && idx == 3'(k)) byte_out = addr_vec[8*(ADDR_BYTES-1-k) +: 8];
    end
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (sel_data && idx == 3'(k)) byte_out = data_vec[8*(DATA_BYTES-1-k) +: 8];
    end
  end

  // Read byte idx lands in the same MSB-first position it was sent from.
  always_comb begin
    rdata_next = rdata_cur;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (idx == 3'(k)) rdata_next[8*(DATA_BYTES-1-k) +: 8] = rx_byte;
    end
  end

endmodule

// File: rtl/i2c_register_access.sv
// Register-level I2C transactions (write, read, optional read-back verify,
// bounded retry) built on an external byte-level send engine.
module i2c_register_access
  import i2c_access_pkg::*;
#(
  parameter int ADDR_BYTES  = 1,
  parameter int DATA_BYTES  = 1,
  parameter int VERIFY_EN   = 0,
  parameter int MAX_RETRIES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              i2c_addr,
  input  logic [8*ADDR_BYTES-1:0] reg_addr,
  input  logic [8*DATA_BYTES-1:0] reg_wdata,
  input  logic                    reg_op_rd,
  input  logic                    reg_op_start,
  output logic                    reg_op_ready,
  output logic                    reg_op_done,
  output logic [1:0]              reg_op_err,
  output logic [8*DATA_BYTES-1:0] reg_rdata,
  output logic [7:0]              tx_data,
  output logic                    i2c_start,
  output logic                    i2c_stop,
  output logic                    i2c_read,
  output logic                    i2c_read_nack,
  output logic                    tx_start,
  input  logic                    i2c_send_done,
  input  logic                    i2c_send_ready,
  input  logic [7:0]              rx_data,
  input  logic                    i2c_ack_err
);

  state_e                  state, state_nxt;
  logic [2:0]              cnt, cnt_nxt;
  logic [2:0]              retry_cnt;
  logic [6:0]              addr_q;
  logic [8*ADDR_BYTES-1:0] reg_addr_q;
  logic [8*DATA_BYTES-1:0] wdata_q;
  logic                    rd_q;
  logic                    verify_q;
  logic                    nack_q;
  logic                    ready_q;

  logic                    sel_data;
  logic [7:0]              slice_byte;
  logic [8*DATA_BYTES-1:0] rdata_nxt;

  logic                    accept, shift_rx, nack_set, verify_start, retry_go, finish;
  err_e                    fail_code;

  logic in_read, last_addr, last_data, nacked;
  assign in_read   = rd_q | verify_q;
  assign last_addr = (cnt == 3'(ADDR_BYTES-1));
  assign last_data = (cnt == 3'(DATA_BYTES-1));
  assign nacked    = i2c_send_done & i2c_ack_err;

  assign reg_op_ready = ready_q & i2c_send_ready;

  // Outcome of the attempt that just ended; a NACK takes precedence.
  always_comb begin
    fail_code = ERR_OK;
    if (nack_q)                                 fail_code = ERR_NACK;
    else if (verify_q && reg_rdata != wdata_q)  fail_code = ERR_VERIFY;
  end

  i2c_byte_slicer #(
    .ADDR_BYTES (ADDR_BYTES),
    .DATA_BYTES (DATA_BYTES)
  ) u_slicer (
    .addr_vec   (reg_addr_q),
    .data_vec   (wdata_q),
    .sel_data   (sel_data),
    .idx        (cnt),
    .byte_out   (slice_byte),
    .rdata_cur  (reg_rdata),
    .rx_byte    (rx_data),
    .rdata_next (rdata_nxt)
  );

  // State register and per-phase byte counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Byte-engine outputs and next-state decode.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    tx_data       = '0;
    i2c_start     = 1'b0;
    i2c_stop      = 1'b0;
    i2c_read      = 1'b0;
    i2c_read_nack = 1'b0;
    sel_data      = 1'b0;
    accept        = 1'b0;
    shift_rx      = 1'b0;
    nack_set      = 1'b0;
    verify_start  = 1'b0;
    retry_go      = 1'b0;
    finish        = 1'b0;

    tx_start = (state == SADDR_W) || (state == RADDR) || (state == WDATA) ||
               (state == SADDR_R) || (state == RDATA);

    // Byte attributes stay stable across the ISSUE and WAIT state of a byte.
    case (state)
      SADDR_W, SADDR_W_WAIT: begin
        tx_data   = saddr_byte(addr_q, RW_WRITE);
        i2c_start = 1'b1;
      end
      RADDR, RADDR_WAIT: tx_data = slice_byte;
      WDATA, WDATA_WAIT: begin
        sel_data = 1'b1;
        tx_data  = slice_byte;
        i2c_stop = last_data;
      end
      SADDR_R, SADDR_R_WAIT: begin
        tx_data   = saddr_byte(addr_q, RW_READ);
        i2c_start = 1'b1;
      end
      RDATA, RDATA_WAIT: begin
        i2c_read      = 1'b1;
        i2c_read_nack = last_data;
        i2c_stop      = last_data;
      end
      default: ;
    endcase

    case (state)
      IDLE: begin
        if (reg_op_start && reg_op_ready) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SADDR_W;
        end
      end
      SADDR_W: state_nxt = SADDR_W_WAIT;
      SADDR_W_WAIT: begin
        if (nacked) begin
          nack_set  = 1'b1;
          state_nxt = CHECK;
        end else if (i2c_send_done) begin
          cnt_nxt   = '0;
          state_nxt = RADDR;
        end
      end
      RADDR: state_nxt = RADDR_WAIT;
      RADDR_WAIT: begin
        if (nacked) begin
          nack_set  = 1'b1;
          state_nxt = CHECK;
        end else if (i2c_send_done) begin
          if (last_addr) begin
            cnt_nxt   = '0;
            state_nxt = in_read ? SADDR_R : WDATA;
          end else begin
            cnt_nxt   = cnt + 3'd1;
            state_nxt = RADDR;
          end
        end
      end
      WDATA: state_nxt = WDATA_WAIT;
      WDATA_WAIT: begin
        if (nacked) begin
          nack_set  = 1'b1;
          state_nxt = CHECK;
        end else if (i2c_send_done) begin
          if (!last_data) begin
            cnt_nxt   = cnt + 3'd1;
            state_nxt = WDATA;
          end else if (VERIFY_EN != 0) begin
            cnt_nxt      = '0;
            verify_start = 1'b1;
            state_nxt    = SADDR_W;
          end else begin
            state_nxt = CHECK;
          end
        end
      end
      SADDR_R: state_nxt = SADDR_R_WAIT;
      SADDR_R_WAIT: begin
        if (nacked) begin
          nack_set  = 1'b1;
          state_nxt = CHECK;
        end else if (i2c_send_done) begin
          cnt_nxt   = '0;
          state_nxt = RDATA;
        end
      end
      RDATA: state_nxt = RDATA_WAIT;
      RDATA_WAIT: begin
        // The master drives ACK/NACK on reads, so i2c_ack_err is not meaningful here.
        if (i2c_send_done) begin
          shift_rx = 1'b1;
          if (last_data) begin
            state_nxt = CHECK;
          end else begin
            cnt_nxt   = cnt + 3'd1;
            state_nxt = RDATA;
          end
        end
      end
      CHECK: begin
        if (fail_code != ERR_OK && retry_cnt != 3'(MAX_RETRIES)) begin
          retry_go  = 1'b1;
          state_nxt = RETRY;
        end else begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RETRY: begin
        cnt_nxt   = '0;
        state_nxt = SADDR_W;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, retry bookkeeping, read data and completion reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b0;
      reg_op_done <= 1'b0;
      reg_op_err  <= ERR_OK;
      reg_rdata   <= '0;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      verify_q    <= 1'b0;
      nack_q      <= 1'b0;
      retry_cnt   <= '0;
    end else begin
      ready_q     <= (state_nxt == IDLE);
      reg_op_done <= finish;
      if (accept) begin
        addr_q     <= i2c_addr;
        reg_addr_q <= reg_addr;
        wdata_q    <= reg_wdata;
        rd_q       <= reg_op_rd;
        verify_q   <= 1'b0;
        nack_q     <= 1'b0;
        retry_cnt  <= '0;
        reg_op_err <= ERR_OK;
      end
      if (nack_set)     nack_q   <= 1'b1;
      if (verify_start) verify_q <= 1'b1;
      if (retry_go) begin
        retry_cnt <= retry_cnt + 3'd1;
        verify_q  <= 1'b0;
        nack_q    <= 1'b0;
      end
      if (shift_rx) reg_rdata  <= rdata_nxt;
      if (finish)   reg_op_err <= fail_code;
    end
  end

endmodule

// File: tb/tb_i2c_register_access.sv
// Directed bench: three controller configurations share one byte-engine model;
// sel chooses which instance is being exercised.
module tb_i2c_register_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [6:0]  dev_addr;
  logic [15:0] op_addr;
  logic [15:0] op_wdata;
  logic        op_rd;
  logic        op_start;
  logic        send_done;
  logic        ack_err;
  logic [7:0]  rx;
  logic        send_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Per-instance outputs.
  logic       ready_v [3];
  logic       done_v  [3];
  logic [1:0] err_v   [3];
  logic [7:0] tx_v    [3];
  logic       st_v    [3];
  logic       sp_v    [3];
  logic       rd_v    [3];
  logic       nk_v    [3];
  logic       ts_v    [3];
  logic [7:0]  a_rdata;
  logic [15:0] b_rdata;
  logic [7:0]  c_rdata;

  logic start_g [3];
  logic done_g  [3];
  for (genvar g = 0; g < 3; g++) begin : g_gate
    assign start_g[g] = op_start  && (sel == 2'(g));
    assign done_g[g]  = send_done && (sel == 2'(g));
  end

  // a: 2-byte address, 1-byte data
  i2c_register_access #(.ADDR_BYTES(2), .DATA_BYTES(1), .VERIFY_EN(0), .MAX_RETRIES(0)) u_a (
    .clk(clk), .rst(rst), .i2c_addr(dev_addr), .reg_addr(op_addr), .reg_wdata(op_wdata[7:0]),
    .reg_op_rd(op_rd), .reg_op_start(start_g[0]), .reg_op_ready(ready_v[0]), .reg_op_done(done_v[0]),
    .reg_op_err(err_v[0]), .reg_rdata(a_rdata), .tx_data(tx_v[0]), .i2c_start(st_v[0]),
    .i2c_stop(sp_v[0]), .i2c_read(rd_v[0]), .i2c_read_nack(nk_v[0]), .tx_start(ts_v[0]),
    .i2c_send_done(done_g[0]), .i2c_send_ready(send_ready), .rx_data(rx), .i2c_ack_err(ack_err));

  // b: 1-byte address, 2-byte data
  i2c_register_access #(.ADDR_BYTES(1), .DATA_BYTES(2), .VERIFY_EN(0), .MAX_RETRIES(0)) u_b (
    .clk(clk), .rst(rst), .i2c_addr(dev_addr), .reg_addr(op_addr[7:0]), .reg_wdata(op_wdata),
    .reg_op_rd(op_rd), .reg_op_start(start_g[1]), .reg_op_ready(ready_v[1]), .reg_op_done(done_v[1]),
    .reg_op_err(err_v[1]), .reg_rdata(b_rdata), .tx_data(tx_v[1]), .i2c_start(st_v[1]),
    .i2c_stop(sp_v[1]), .i2c_read(rd_v[1]), .i2c_read_nack(nk_v[1]), .tx_start(ts_v[1]),
    .i2c_send_done(done_g[1]), .i2c_send_ready(send_ready), .rx_data(rx), .i2c_ack_err(ack_err));

  // c: verify enabled, one retry
  i2c_register_access #(.ADDR_BYTES(1), .DATA_BYTES(1), .VERIFY_EN(1), .MAX_RETRIES(1)) u_c (
    .clk(clk), .rst(rst), .i2c_addr(dev_addr), .reg_addr(op_addr[15:8]), .reg_wdata(op_wdata[15:8]),
    .reg_op_rd(op_rd), .reg_op_start(start_g[2]), .reg_op_ready(ready_v[2]), .reg_op_done(done_v[2]),
    .reg_op_err(err_v[2]), .reg_rdata(c_rdata), .tx_data(tx_v[2]), .i2c_start(st_v[2]),
    .i2c_stop(sp_v[2]), .i2c_read(rd_v[2]), .i2c_read_nack(nk_v[2]), .tx_start(ts_v[2]),
    .i2c_send_done(done_g[2]), .i2c_send_ready(send_ready), .rx_data(rx), .i2c_ack_err(ack_err));

  // Selected instance view.
  logic        m_ready, m_done, m_st, m_sp, m_rd, m_nk, m_ts;
  logic [1:0]  m_err;
  logic [7:0]  m_tx;
  logic [15:0] m_rdata;
  assign m_ready = ready_v[sel];
  assign m_done  = done_v[sel];
  assign m_err   = err_v[sel];
  assign m_tx    = tx_v[sel];
  assign m_st    = st_v[sel];
  assign m_sp    = sp_v[sel];
  assign m_rd    = rd_v[sel];
  assign m_nk    = nk_v[sel];
  assign m_ts    = ts_v[sel];
  assign m_rdata = (sel == 2'd0) ? {8'h00, a_rdata} : (sel == 2'd1) ? b_rdata : {8'h00, c_rdata};

  // Byte-engine model: logs each byte operation, answers 2 clocks later.
  logic [7:0] log_data  [32];
  logic [3:0] log_flags [32];   // {start, stop, read, read_nack}
  logic [7:0] rd_pat    [2];
  int n_log   = 0;
  int rd_idx  = 0;
  int nack_at = -1;

  initial begin
    int  cd;
    int  cur_idx;
    logic cur_read;
    cd = 0; cur_idx = 0; cur_read = 1'b0;
    send_done = 1'b0; ack_err = 1'b0; rx = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      send_done = 1'b0;
      ack_err   = 1'b0;
      if (rst) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          send_done = 1'b1;
          ack_err   = (cur_idx == nack_at) && !cur_read;
          if (cur_read) begin
            rx = rd_pat[rd_idx % 2];
            rd_idx++;
          end
        end
      end else if (m_ts) begin
        if (n_log < 32) begin
          log_data[n_log]  = m_tx;
          log_flags[n_log] = {m_st, m_sp, m_rd, m_nk};
        end
        cur_idx  = n_log;
        cur_read = m_rd;
        n_log++;
        cd = 2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 32; i++) begin
      log_data[i]  = 'x;
      log_flags[i] = 'x;
    end
    n_log  = 0;
    rd_idx = 0;
  endtask

  task automatic check_byte(input int i, input logic [7:0] d, input logic [3:0] f);
    check($sformatf("byte%0d_data", i), 32'(log_data[i]), 32'(d));
    check($sformatf("byte%0d_flags", i), 32'(log_flags[i]), 32'(f));
  endtask

  task automatic check_flags(input int i, input logic [3:0] f);
    check($sformatf("byte%0d_flags", i), 32'(log_flags[i]), 32'(f));
  endtask

  task automatic go(input logic [1:0] s, input logic rd, input logic [15:0] ra, input logic [15:0] wd);
    @(negedge clk);
    sel = s; op_rd = rd; op_addr = ra; op_wdata = wd; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int cyc;
    cyc = 0;
    while (m_done !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(m_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; dev_addr = 7'h30; op_addr = '0; op_wdata = '0;
    op_rd = 1'b0; op_start = 1'b0; send_ready = 1'b1;
    rd_pat[0] = 8'h00; rd_pat[1] = 8'h00;
    clear_log();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(m_ready), 32'd0);
    check("rst_done",  32'(m_done),  32'd0);
    check("rst_err",   32'(m_err),   32'd0);
    check("rst_txs",   32'(m_ts),    32'd0);
    check("rst_tx",    32'(m_tx),    32'd0);
    check("rst_rdata", 32'(m_rdata), 32'd0);
    rst = 1'b0;
    #1 check("ready_at_release", 32'(m_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(m_ready), 32'd1);

    // Write: 2-byte register address, 1 data byte
    clear_log();
    go(2'd0, 1'b0, 16'h3012, 16'h00A5);
    check("ready_busy", 32'(m_ready), 32'd0);
    wait_done(100);
    check("wr_err", 32'(m_err), 32'd0);
    @(negedge clk);
    check("wr_done_pulse", 32'(m_done), 32'd0);
    check("wr_nbytes", 32'(n_log), 32'd4);
    check_byte(0, 8'h60, 4'b1000);
    check_byte(1, 8'h30, 4'b0000);
    check_byte(2, 8'h12, 4'b0000);
    check_byte(3, 8'hA5, 4'b0100);

    // NACK on 2nd address byte, no retries
    clear_log();
    nack_at = 2;
    go(2'd0, 1'b0, 16'h3012, 16'h0077);
    wait_done(100);
    check("nack_err", 32'(m_err), 32'd1);
    check("nack_nbytes", 32'(n_log), 32'd3);
    check_byte(2, 8'h12, 4'b0000);
    nack_at = -1;
    repeat (3) @(negedge clk);
    check("nack_err_held", 32'(m_err), 32'd1);
    check("nack_no_done", 32'(m_done), 32'd0);

    // Start held through a transaction: exactly one accepted
    clear_log();
    @(negedge clk);
    sel = 2'd0; op_rd = 1'b0; op_addr = 16'h0101; op_wdata = 16'h003C; op_start = 1'b1;
    @(negedge clk);
    check("held_ready_low", 32'(m_ready), 32'd0);
    wait_done(100);
    op_start = 1'b0;
    check("held_err", 32'(m_err), 32'd0);
    repeat (6) @(negedge clk);
    check("held_nbytes", 32'(n_log), 32'd4);
    check_byte(0, 8'h60, 4'b1000);
    check_byte(3, 8'h3C, 4'b0100);

    // Reset during the data-byte wait
    clear_log();
    go(2'd0, 1'b0, 16'h3012, 16'h0099);
    for (int i = 0; i < 50 && n_log < 4; i++) @(negedge clk);
    check("rst_reach_wdata", 32'(n_log), 32'd4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_txs",   32'(m_ts),    32'd0);
    check("mid_rst_tx",    32'(m_tx),    32'd0);
    check("mid_rst_stop",  32'(m_sp),    32'd0);
    check("mid_rst_ready", 32'(m_ready), 32'd0);
    check("mid_rst_done",  32'(m_done),  32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", 32'(m_done), 32'd0);
    end
    rst = 1'b0;
    #1 check("mid_rst_ready_rel", 32'(m_ready), 32'd0);
    @(negedge clk);
    check("mid_rst_ready_clk", 32'(m_ready), 32'd1);
    check("mid_rst_no_done2",  32'(m_done),  32'd0);
    clear_log();
    go(2'd0, 1'b0, 16'h3012, 16'h005C);
    wait_done(100);
    check("post_rst_err", 32'(m_err), 32'd0);
    check("post_rst_nbytes", 32'(n_log), 32'd4);
    check_byte(3, 8'h5C, 4'b0100);

    // Read: 1-byte address, 2 data bytes
    clear_log();
    rd_pat[0] = 8'hBE; rd_pat[1] = 8'hEF;
    go(2'd1, 1'b1, 16'h000C, 16'h0000);
    wait_done(100);
    check("rd_err", 32'(m_err), 32'd0);
    check("rd_rdata", 32'(m_rdata), 32'h0000BEEF);
    check("rd_nbytes", 32'(n_log), 32'd5);
    check_byte(0, 8'h60, 4'b1000);
    check_byte(1, 8'h0C, 4'b0000);
    check_byte(2, 8'h61, 4'b1000);
    check_flags(3, 4'b0010);
    check_flags(4, 4'b0111);

    // Verify mismatch with one retry: two full write+read attempts
    clear_log();
    rd_pat[0] = 8'h5A; rd_pat[1] = 8'h5A;
    go(2'd2, 1'b0, 16'h1200, 16'hA500);
    wait_done(300);
    check("vfy_err", 32'(m_err), 32'd2);
    check("vfy_rdata", 32'(m_rdata), 32'h5A);
    check("vfy_nbytes", 32'(n_log), 32'd14);
    check_byte(2, 8'hA5, 4'b0100);
    check_byte(3, 8'h60, 4'b1000);
    check_byte(5, 8'h61, 4'b1000);
    check_flags(6, 4'b0111);
    check_byte(7, 8'h60, 4'b1000);
    check_byte(9, 8'hA5, 4'b0100);

    // Verify match: one attempt, no error
    clear_log();
    rd_pat[0] = 8'hA5; rd_pat[1] = 8'hA5;
    go(2'd2, 1'b0, 16'h1200, 16'hA500);
    wait_done(300);
    check("vfy_ok_err", 32'(m_err), 32'd0);
    check("vfy_ok_rdata", 32'(m_rdata), 32'hA5);
    check("vfy_ok_nbytes", 32'(n_log), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
